// File: rtl/is_uart_rx_fsm.sv
// UART receive FSM: oversamples the serial line, recovers DATA_W-bit frames and
// holds the byte with parity/framing/overrun status until the core acknowledges it.
module is_uart_rx_fsm #(
    parameter int DATA_W     = 8,
    parameter int OVS        = 16,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              os_ce_i,
    input  logic              rxd_i,
    input  logic              rx_ack_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_data_en_o,
    output logic              rx_rdy_r_o,
    output logic              rx_par_err_o,
    output logic              rx_frm_err_o,
    output logic              rx_ovr_r_o,
    output logic              rxct_r_o
);

    localparam int TICK_W = (OVS > 2) ? $clog2(OVS) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVS / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RSTRB = 3'd1;
    localparam logic [2:0] S_RDT   = 3'd2;
    localparam logic [2:0] S_RPARB = 3'd3;
    localparam logic [2:0] S_RSTB  = 3'd4;
    localparam logic [2:0] S_WEND  = 3'd5;

    // Received parity bit against the data; 1 means the frame carries a parity error.
    function automatic logic parity_err(input logic par_bit, input logic [DATA_W-1:0] data);
        return par_bit ^ (^data) ^ PARITY_ODD;
    endfunction

    logic              sync1_q;
    logic              rxd_s_q;

    logic [2:0]        state_q,     state_d;
    logic [TICK_W-1:0] tick_cnt_q,  tick_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-1:0] shift_q,     shift_d;
    logic              par_err_q,   par_err_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic              data_en_q,   data_en_d;
    logic              par_flag_q,  par_flag_d;
    logic              frm_flag_q,  frm_flag_d;
    logic              rdy_q,       rdy_d;
    logic              ovr_q,       ovr_d;
    logic              rxct_q,      rxct_d;

    // Two-stage synchronizer for the asynchronous line; resets to the idle (high) level.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q <= 1'b1;
            rxd_s_q <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            rxd_s_q <= sync1_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        data_d     = data_q;
        data_en_d  = 1'b0;
        par_flag_d = par_flag_q;
        frm_flag_d = frm_flag_q;
        rxct_d     = rxct_q;

        if (os_ce_i) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s_q) begin
                        state_d    = S_RSTRB;
                        tick_cnt_d = '0;
                    end
                end
                S_RSTRB: begin
                    if (tick_cnt_q == TICK_HALF) begin
                        tick_cnt_d = '0;
                        if (rxd_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_RDT;
                            rxct_d  = 1'b0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                S_RDT: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rxd_s_q, shift_q[DATA_W-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = PARITY_EN ? S_RPARB : S_RSTB;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                S_RPARB: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        par_err_d  = parity_err(rxd_s_q, shift_q);
                        state_d    = S_RSTB;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                S_RSTB: begin
                    // Only the first stop bit is checked; extra stop bits look like idle line.
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        data_d     = shift_q;
                        data_en_d  = 1'b1;
                        par_flag_d = PARITY_EN ? par_err_q : 1'b0;
                        frm_flag_d = ~rxd_s_q;
                        if (rxd_s_q) begin
                            state_d = S_IDLE;
                            rxct_d  = 1'b1;
                        end else begin
                            state_d = S_WEND;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                S_WEND: begin
                    // A held-low line (break) must return high before a new start is accepted.
                    if (rxd_s_q) begin
                        state_d = S_IDLE;
                        rxct_d  = 1'b1;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    rxct_d     = 1'b1;
                end
            endcase
        end
    end

    // Handshake with the core: a completion wins over a simultaneous acknowledge.
    always_comb begin
        rdy_d = rdy_q;
        ovr_d = ovr_q;
        if (data_en_q) begin
            rdy_d = 1'b1;
        end else if (rx_ack_i) begin
            rdy_d = 1'b0;
        end
        if (data_en_q && rdy_q && !rx_ack_i) begin
            ovr_d = 1'b1;
        end else if (rx_ack_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            data_en_q  <= 1'b0;
            par_flag_q <= 1'b0;
            frm_flag_q <= 1'b0;
            rdy_q      <= 1'b0;
            ovr_q      <= 1'b0;
            rxct_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            data_en_q  <= data_en_d;
            par_flag_q <= par_flag_d;
            frm_flag_q <= frm_flag_d;
            rdy_q      <= rdy_d;
            ovr_q      <= ovr_d;
            rxct_q     <= rxct_d;
        end
    end

    // Datapath scratch registers are fully rewritten every frame before use.
    always_ff @(posedge clk_i) begin
        shift_q   <= shift_d;
        par_err_q <= par_err_d;
    end

    assign rx_data_o    = data_q;
    assign rx_data_en_o = data_en_q;
    assign rx_rdy_r_o   = rdy_q;
    assign rx_par_err_o = par_flag_q;
    assign rx_frm_err_o = frm_flag_q;
    assign rx_ovr_r_o   = ovr_q;
    assign rxct_r_o     = rxct_q;

endmodule

// File: tb/tb_is_uart_rx_fsm.sv
// Bench for is_uart_rx_fsm: drives serial frames tick by tick and compares the
// received byte and status flags with a frame-level reference model.
module tb_is_uart_rx_fsm;

    localparam int DATA_W     = 8;
    localparam int OVS        = 16;
    localparam bit PARITY_EN  = 1'b1;
    localparam bit PARITY_ODD = 1'b0;
    localparam int CE_DIV     = 3;

    logic              clk      = 1'b0;
    logic              rst_i    = 1'b0;
    logic              os_ce_i  = 1'b0;
    logic              rxd_i    = 1'b1;
    logic              rx_ack_i = 1'b0;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_data_en_o;
    logic              rx_rdy_r_o;
    logic              rx_par_err_o;
    logic              rx_frm_err_o;
    logic              rx_ovr_r_o;
    logic              rxct_r_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int en_cnt       = 0;

    is_uart_rx_fsm #(
        .DATA_W    (DATA_W),
        .OVS       (OVS),
        .PARITY_EN (PARITY_EN),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .os_ce_i     (os_ce_i),
        .rxd_i       (rxd_i),
        .rx_ack_i    (rx_ack_i),
        .rx_data_o   (rx_data_o),
        .rx_data_en_o(rx_data_en_o),
        .rx_rdy_r_o  (rx_rdy_r_o),
        .rx_par_err_o(rx_par_err_o),
        .rx_frm_err_o(rx_frm_err_o),
        .rx_ovr_r_o  (rx_ovr_r_o),
        .rxct_r_o    (rxct_r_o)
    );

    always #5 clk = ~clk;

    initial begin : ce_gen
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            os_ce_i = ((cnt % CE_DIV) == 0);
        end
    end

    initial begin : en_monitor
        forever begin
            @(negedge clk);
            if (rx_data_en_o) en_cnt++;
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached, required completion before limit");
        $fatal(1, "watchdog");
    end

    function automatic logic good_par(input logic [DATA_W-1:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
        return logic'(ones % 2) ^ PARITY_ODD;
    endfunction

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (os_ce_i !== 1'b1) @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd_i = b;
        wait_ticks(OVS);
    endtask

    // Drives start, data, parity and leaves the line at the stop level.
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic pbit, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
        if (PARITY_EN) drive_bit(pbit);
        rxd_i = stop;
    endtask

    task automatic wait_done(input bit ack_with, output bit got, output bit narrow,
                             output logic [DATA_W-1:0] d, output logic pe, output logic fe);
        got = 0; narrow = 0; d = '0; pe = 0; fe = 0;
        for (int i = 0; i < 64 * CE_DIV && !got; i++) begin
            @(negedge clk);
            if (rx_data_en_o) begin
                got = 1;
                d   = rx_data_o;
                pe  = rx_par_err_o;
                fe  = rx_frm_err_o;
                if (ack_with) rx_ack_i = 1'b1;
                @(negedge clk);
                rx_ack_i = 1'b0;
                narrow = !rx_data_en_o;
            end
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        rx_ack_i = 1'b1;
        @(negedge clk);
        rx_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [DATA_W+5:0] exp_v;
        exp_v = {{DATA_W{1'b0}}, 6'b000001};
        repeat (4) @(negedge clk);
        tests_run++;
        if ({rx_data_o, rx_data_en_o, rx_rdy_r_o, rx_par_err_o, rx_frm_err_o, rx_ovr_r_o, rxct_r_o} !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_hold: outputs=%h required=%h", {rx_data_o, rx_data_en_o, rx_rdy_r_o,
                     rx_par_err_o, rx_frm_err_o, rx_ovr_r_o, rxct_r_o}, exp_v);
        end
        rst_i = 1'b1;
        wait_ticks(2 * OVS);
        @(negedge clk);
        tests_run++;
        if ({rx_data_o, rx_data_en_o, rx_rdy_r_o, rx_par_err_o, rx_frm_err_o, rx_ovr_r_o, rxct_r_o} !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_idle: outputs=%h required=%h", {rx_data_o, rx_data_en_o, rx_rdy_r_o,
                     rx_par_err_o, rx_frm_err_o, rx_ovr_r_o, rxct_r_o}, exp_v);
        end
    endtask

    task automatic test_basic();
        bit got, narrow; logic [DATA_W-1:0] d; logic pe, fe;
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_done(0, got, narrow, d, pe, fe);
        tests_run++;
        if (got !== 1'b1 || narrow !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_pulse: got=%0d one_clk=%0d required 1 1", got, narrow);
        end
        tests_run++;
        if ({d, pe, fe} !== {8'hA5, 2'b00}) begin
            tests_failed++;
            $display("FAIL basic_data: data=%h par=%b frm=%b required a5 0 0", d, pe, fe);
        end
        wait_ticks(7 + OVS);
        tests_run++;
        if ({rx_rdy_r_o, rx_ovr_r_o, rxct_r_o} !== 3'b101) begin
            tests_failed++;
            $display("FAIL basic_status: rdy/ovr/rxct=%b required 101", {rx_rdy_r_o, rx_ovr_r_o, rxct_r_o});
        end
        do_ack();
        tests_run++;
        if (rx_rdy_r_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_ack: rdy=%b required 0", rx_rdy_r_o);
        end
    endtask

    task automatic test_parity();
        bit got, narrow; logic [DATA_W-1:0] d; logic pe, fe;
        send_frame(8'h07, 1'b0, 1'b1);
        wait_done(0, got, narrow, d, pe, fe);
        tests_run++;
        if (got !== 1'b1 || {d, pe, fe} !== {8'h07, 2'b10}) begin
            tests_failed++;
            $display("FAIL parity_err: got=%0d data=%h par=%b frm=%b required 1 07 1 0", got, d, pe, fe);
        end
        wait_ticks(7 + OVS);
        do_ack();
    endtask

    task automatic test_framing();
        bit got, narrow; logic [DATA_W-1:0] d; logic pe, fe; int n0;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_done(0, got, narrow, d, pe, fe);
        tests_run++;
        if (got !== 1'b1 || {d, pe, fe} !== {8'h3C, 2'b01}) begin
            tests_failed++;
            $display("FAIL framing_err: got=%0d data=%h par=%b frm=%b required 1 3c 0 1", got, d, pe, fe);
        end
        n0 = en_cnt;
        wait_ticks(7 + 3 * OVS);
        tests_run++;
        if (rxct_r_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL framing_wend: rxct=%b required 0 while line low", rxct_r_o);
        end
        rxd_i = 1'b1;
        wait_ticks(4);
        tests_run++;
        if (rxct_r_o !== 1'b1 || en_cnt !== n0) begin
            tests_failed++;
            $display("FAIL framing_release: rxct=%b extra_bytes=%0d required 1 0", rxct_r_o, en_cnt - n0);
        end
        wait_ticks(OVS);
        do_ack();
    endtask

    task automatic test_glitch();
        int n0; bit saw_busy;
        n0 = en_cnt;
        saw_busy = 0;
        rxd_i = 1'b0;
        wait_ticks(4);
        rxd_i = 1'b1;
        repeat (3 * OVS * CE_DIV) begin
            @(negedge clk);
            if (rxct_r_o !== 1'b1) saw_busy = 1;
        end
        tests_run++;
        if (saw_busy !== 1'b0 || en_cnt !== n0) begin
            tests_failed++;
            $display("FAIL glitch: rxct_dropped=%0d bytes=%0d required 0 0", saw_busy, en_cnt - n0);
        end
    endtask

    task automatic test_back_to_back();
        bit got, narrow; logic [DATA_W-1:0] d; logic pe, fe;
        send_frame(8'h11, good_par(8'h11), 1'b1);
        wait_done(0, got, narrow, d, pe, fe);
        wait_ticks(7);
        send_frame(8'h22, good_par(8'h22), 1'b1);
        wait_done(0, got, narrow, d, pe, fe);
        wait_ticks(7 + OVS);
        tests_run++;
        if ({rx_ovr_r_o, rx_rdy_r_o, rx_data_o} !== {2'b11, 8'h22}) begin
            tests_failed++;
            $display("FAIL b2b_overrun: ovr=%b rdy=%b data=%h required 1 1 22", rx_ovr_r_o, rx_rdy_r_o, rx_data_o);
        end
        do_ack();
        tests_run++;
        if ({rx_ovr_r_o, rx_rdy_r_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL b2b_ack_clear: ovr=%b rdy=%b required 0 0", rx_ovr_r_o, rx_rdy_r_o);
        end
        send_frame(8'h11, good_par(8'h11), 1'b1);
        wait_done(0, got, narrow, d, pe, fe);
        wait_ticks(7);
        send_frame(8'h22, good_par(8'h22), 1'b1);
        wait_done(1, got, narrow, d, pe, fe);
        wait_ticks(7 + OVS);
        tests_run++;
        if ({got, rx_ovr_r_o, rx_rdy_r_o, rx_data_o} !== {3'b101, 8'h22}) begin
            tests_failed++;
            $display("FAIL b2b_coincident_ack: got=%0d ovr=%b rdy=%b data=%h required 1 0 1 22",
                     got, rx_ovr_r_o, rx_rdy_r_o, rx_data_o);
        end
        do_ack();
    endtask

    task automatic test_random();
        bit got, narrow; logic [DATA_W-1:0] d, td; logic pe, fe, par_ok, stop;
        logic rdy_m, ovr_m; int mode;
        rdy_m = 1'b0;
        ovr_m = 1'b0;
        for (int k = 0; k < 10; k++) begin
            td     = DATA_W'($urandom);
            par_ok = ($urandom_range(0, 3) != 0);
            stop   = ($urandom_range(0, 4) != 0);
            mode   = $urandom_range(0, 2);
            send_frame(td, good_par(td) ^ !par_ok, stop);
            wait_done(mode == 1, got, narrow, d, pe, fe);
            if (rdy_m && mode != 1) ovr_m = 1'b1;
            else if (mode == 1) ovr_m = 1'b0;
            rdy_m = 1'b1;
            tests_run++;
            if (got !== 1'b1 || {d, pe, fe} !== {td, !par_ok, !stop}) begin
                tests_failed++;
                $display("FAIL random_frame[%0d]: got=%0d data=%h par=%b frm=%b required 1 %h %b %b",
                         k, got, d, pe, fe, td, !par_ok, !stop);
            end
            if (!stop) begin
                wait_ticks(7 + OVS);
                rxd_i = 1'b1;
                wait_ticks(2);
            end
            wait_ticks(7 + $urandom_range(0, OVS));
            tests_run++;
            if ({rx_rdy_r_o, rx_ovr_r_o, rxct_r_o} !== {rdy_m, ovr_m, 1'b1}) begin
                tests_failed++;
                $display("FAIL random_status[%0d]: rdy/ovr/rxct=%b required %b", k,
                         {rx_rdy_r_o, rx_ovr_r_o, rxct_r_o}, {rdy_m, ovr_m, 1'b1});
            end
            if (mode == 2) begin
                do_ack();
                rdy_m = 1'b0;
                ovr_m = 1'b0;
            end
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        bit got, narrow; logic [DATA_W-1:0] d; logic pe, fe;
        logic [DATA_W-1:0] fr;
        send_frame(8'hC3, good_par(8'hC3), 1'b1);
        wait_done(0, got, narrow, d, pe, fe);
        wait_ticks(7 + OVS);
        fr = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(fr[i]);
        rxd_i = fr[4];
        wait_ticks(OVS / 2);
        tests_run++;
        if ({rxct_r_o, rx_rdy_r_o, rx_data_o} !== {2'b01, 8'hC3}) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: rxct=%b rdy=%b data=%h required 0 1 c3", rxct_r_o, rx_rdy_r_o, rx_data_o);
        end
        #2;
        rst_i = 1'b0;
        #1;
        tests_run++;
        if ({rx_data_o, rx_data_en_o, rx_rdy_r_o, rx_par_err_o, rx_frm_err_o, rx_ovr_r_o, rxct_r_o}
            !== {{DATA_W{1'b0}}, 6'b000001}) begin
            tests_failed++;
            $display("FAIL reset_mid_async: outputs=%h required %h", {rx_data_o, rx_data_en_o, rx_rdy_r_o,
                     rx_par_err_o, rx_frm_err_o, rx_ovr_r_o, rxct_r_o}, {{DATA_W{1'b0}}, 6'b000001});
        end
        rxd_i = 1'b1;
        repeat (5) @(negedge clk);
        rst_i = 1'b1;
        wait_ticks(2 * OVS);
        send_frame(fr, good_par(fr), 1'b1);
        wait_done(0, got, narrow, d, pe, fe);
        tests_run++;
        if (got !== 1'b1 || {d, pe, fe} !== {8'h5A, 2'b00}) begin
            tests_failed++;
            $display("FAIL reset_mid_next: got=%0d data=%h par=%b frm=%b required 1 5a 0 0", got, d, pe, fe);
        end
        wait_ticks(7 + OVS);
        do_ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
